// File: rtl/pixel_packer.sv
// Streaming pixel packer: gathers PIX_PER_WORD pixels into one output word over
// valid/ready handshakes, with early flush on in_last and selectable lane order.
module pixel_packer #(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [PIX_W-1:0]                      in_pixel,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_last,
    input  logic                                  msb_first,
    output logic [PIX_W*PIX_PER_WORD-1:0]         out_word,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [$clog2(PIX_PER_WORD+1)-1:0]     out_count,
    output logic                                  out_last
);

    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int CNT_W  = $clog2(PIX_PER_WORD + 1);
    localparam int FILL_W = $clog2(PIX_PER_WORD);
    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(PIX_PER_WORD - 1);

    // Assembly stage
    logic [WORD_W-1:0] r_asm;
    logic [FILL_W-1:0] r_fill;
    logic              r_order;

    // Output stage
    logic [WORD_W-1:0] r_out_word;
    logic [CNT_W-1:0]  r_out_count;
    logic              r_out_last;
    logic              r_out_valid;

    logic              w_order;
    logic              w_completing;
    logic              w_accept;
    logic              w_load;
    logic [FILL_W-1:0] w_lane;
    logic [WORD_W-1:0] w_merged;

    // The order bit is taken live for the first pixel of a word, latched afterwards.
    assign w_order      = (r_fill == '0) ? msb_first : r_order;
    assign w_lane       = w_order ? (LAST_FILL - r_fill) : r_fill;
    assign w_completing = (r_fill == LAST_FILL) || in_last;

    // Only a word-completing pixel can stall, and only against a full, non-draining output.
    assign in_ready = rst_n && !(w_completing && r_out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_load   = w_accept && w_completing;

    // Unwritten lanes of r_asm are always zero, so the merged word is already padded.
    generate
        for (genvar gi = 0; gi < PIX_PER_WORD; gi++) begin : g_lane
            assign w_merged[gi*PIX_W +: PIX_W] =
                (w_lane == FILL_W'(gi)) ? in_pixel : r_asm[gi*PIX_W +: PIX_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_asm   <= '0;
            r_fill  <= '0;
            r_order <= 1'b0;
        end else if (w_accept) begin
            r_order <= w_order;
            if (w_completing) begin
                r_asm  <= '0;
                r_fill <= '0;
            end else begin
                r_asm  <= w_merged;
                r_fill <= r_fill + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_word  <= '0;
            r_out_count <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_word  <= w_merged;
            r_out_count <= CNT_W'(r_fill) + CNT_W'(1);
            r_out_last  <= in_last;
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_word  = r_out_word;
    assign out_count = r_out_count;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_pixel_packer.sv
// Bench for pixel_packer: hand vectors, backpressure/reset sequences, random traffic
// against a queue-based word model, plus a 10-bit x 3 lane instance.
module tb_pixel_packer;

    localparam int N = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  in_pixel;
    logic        in_valid, in_last, msb_first, out_ready;
    logic        in_ready, out_valid, out_last;
    logic [31:0] out_word;
    logic [2:0]  out_count;

    logic [9:0]  p2;
    logic        v2, l2, m2, or2;
    logic        rdy2, ov2, ol2;
    logic [29:0] ow2;
    logic [1:0]  oc2;

    pixel_packer #(.PIX_W(8), .PIX_PER_WORD(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_pixel(in_pixel), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .msb_first(msb_first),
        .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_last(out_last)
    );

    pixel_packer #(.PIX_W(10), .PIX_PER_WORD(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_pixel(p2), .in_valid(v2),
        .in_ready(rdy2), .in_last(l2), .msb_first(m2),
        .out_word(ow2), .out_valid(ov2), .out_ready(or2),
        .out_count(oc2), .out_last(ol2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: pixels of the word being gathered, and words awaiting the consumer.
    typedef struct {
        logic [31:0] w;
        int          c;
        bit          l;
    } oword_t;

    logic [7:0] m_pix[$];
    bit         m_order;
    oword_t     m_out[$];
    int         n_words = 0;
    bit         e_ready;

    task automatic drive(input logic [7:0] p, input bit v, input bit l, input bit m,
                         input bit ordy, input bit rn);
        in_pixel  = p;
        in_valid  = v;
        in_last   = l;
        msb_first = m;
        out_ready = ordy;
        rst_n     = rn;
        @(negedge clk);
        e_ready = rn && !(((m_pix.size() == N-1) || l) && (m_out.size() != 0) && !ordy);
        chk("in_ready", in_ready, e_ready);
        chk("out_valid", out_valid, m_out.size() != 0);
        if (m_out.size() != 0 && out_valid) begin
            chk("out_word", out_word, m_out[0].w);
            chk("out_count", out_count, m_out[0].c);
            chk("out_last", out_last, m_out[0].l);
        end
    endtask

    task automatic advance();
        oword_t o;
        int     lane;
        if (!rst_n) begin
            m_pix.delete();
            m_out.delete();
        end else begin
            if (m_out.size() != 0 && out_ready) begin
                $display("word %08h count %0d last %0d", out_word, out_count, out_last);
                void'(m_out.pop_front());
                n_words++;
            end
            if (in_valid && e_ready) begin
                if (m_pix.size() == 0) m_order = msb_first;
                m_pix.push_back(in_pixel);
                if (m_pix.size() == N || in_last) begin
                    o.w = '0;
                    for (int k = 0; k < m_pix.size(); k++) begin
                        lane = m_order ? (N - 1 - k) : k;
                        o.w  = o.w | (32'(m_pix[k]) << (8 * lane));
                    end
                    o.c = m_pix.size();
                    o.l = in_last;
                    m_out.push_back(o);
                    m_pix.delete();
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0]  p;
        bit          v, l, m, o;
        bit          e_rdy, e_ov;
        logic [31:0] e_w;
        int          e_c;
        bit          e_l;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] p, input bit v, input bit l, input bit m,
                                input bit o, input bit er, input bit eo,
                                input logic [31:0] w, input int c, input bit el);
        vec_t t;
        t.p = p; t.v = v; t.l = l; t.m = m; t.o = o;
        t.e_rdy = er; t.e_ov = eo; t.e_w = w; t.e_c = c; t.e_l = el;
        return t;
    endfunction

    vec_t tbl[23];

    initial begin
        int acc;
        int base;
        logic [29:0] e2;

        v2 = 1'b0; l2 = 1'b0; m2 = 1'b0; or2 = 1'b1; p2 = '0;

        // Expected outputs are sampled in the row's cycle, before its inputs take effect.
        tbl[0]  = mk(8'h11, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[1]  = mk(8'h22, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[2]  = mk(8'h33, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[3]  = mk(8'h44, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[4]  = mk(8'h11, 1, 0, 1, 1, 1, 1, 32'h44332211, 4, 0);
        tbl[5]  = mk(8'h22, 1, 0, 1, 1, 1, 0, 32'h0, 0, 0);
        tbl[6]  = mk(8'h33, 1, 0, 1, 1, 1, 0, 32'h0, 0, 0);
        tbl[7]  = mk(8'h44, 1, 0, 1, 1, 1, 0, 32'h0, 0, 0);
        tbl[8]  = mk(8'h55, 1, 0, 1, 1, 1, 1, 32'h11223344, 4, 0);
        tbl[9]  = mk(8'h66, 1, 0, 1, 1, 1, 0, 32'h0, 0, 0);
        tbl[10] = mk(8'h77, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[11] = mk(8'h88, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[12] = mk(8'hAA, 1, 0, 0, 1, 1, 1, 32'h55667788, 4, 0);
        tbl[13] = mk(8'hBB, 1, 1, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[14] = mk(8'hCC, 1, 0, 0, 1, 1, 1, 32'h0000BBAA, 2, 1);
        tbl[15] = mk(8'hDD, 1, 1, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[16] = mk(8'h00, 0, 0, 0, 1, 1, 1, 32'h0000DDCC, 2, 1);
        tbl[17] = mk(8'h01, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[18] = mk(8'h02, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[19] = mk(8'h03, 1, 0, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[20] = mk(8'h04, 1, 1, 0, 1, 1, 0, 32'h0, 0, 0);
        tbl[21] = mk(8'h00, 0, 0, 0, 1, 1, 1, 32'h04030201, 4, 1);
        tbl[22] = mk(8'h00, 0, 0, 0, 1, 1, 0, 32'h0, 0, 0);

        // Reset, then the state right after release
        repeat (3) begin
            drive(8'h00, 1, 0, 0, 1, 0);
            advance();
        end
        drive(8'h00, 0, 0, 0, 1, 1);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_word", out_word, 32'h0);
        chk("rst_out_count", out_count, 3'd0);
        chk("rst_out_last", out_last, 1'b0);
        advance();

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].p, tbl[i].v, tbl[i].l, tbl[i].m, tbl[i].o, 1);
            chk("tbl_in_ready", in_ready, tbl[i].e_rdy);
            chk("tbl_out_valid", out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk("tbl_out_word", out_word, tbl[i].e_w);
                chk("tbl_out_count", out_count, tbl[i].e_c);
                chk("tbl_out_last", out_last, tbl[i].e_l);
            end
            advance();
        end

        // Backpressure: 12 pixels offered with the consumer stalled
        acc  = 0;
        base = n_words;
        for (int c = 0; c < 10; c++) begin
            drive(8'(8'h80 + acc), acc < 12, 0, 0, 0, 1);
            if (c == 9) chk("bp_stall_ready", in_ready, 1'b0);
            if (in_valid && in_ready) acc++;
            advance();
        end
        chk("bp_accepted_while_stalled", acc, 7);
        drive(8'(8'h80 + acc), 1, 0, 0, 1, 1);
        chk("bp_drain_and_load", {in_ready, out_valid}, 2'b11);
        if (in_valid && in_ready) acc++;
        advance();
        for (int c = 0; c < 40 && (acc < 12 || m_out.size() != 0); c++) begin
            drive(8'(8'h80 + acc), acc < 12, 0, 0, 1, 1);
            if (in_valid && in_ready) acc++;
            advance();
        end
        chk("bp_all_accepted", acc, 12);
        chk("bp_words_out", n_words - base, 3);

        // Reset with a pending word and a half-built word
        for (int k = 0; k < 6; k++) begin
            drive(8'(k + 1), 1, 0, 0, 0, 1);
            advance();
        end
        drive(8'h07, 1, 0, 0, 0, 0);
        chk("rstmid_in_ready", in_ready, 1'b0);
        chk("rstmid_pending", out_valid, 1'b1);
        advance();
        drive(8'h00, 0, 0, 0, 1, 1);
        chk("rstmid_out_valid", out_valid, 1'b0);
        chk("rstmid_out_count", out_count, 3'd0);
        advance();
        for (int k = 0; k < 4; k++) begin
            drive(8'(8'h21 + k), 1, 0, 0, 1, 1);
            advance();
        end
        drive(8'h00, 0, 0, 0, 1, 1);
        chk("rstmid_clean_word", out_word, 32'h24232221);
        chk("rstmid_clean_count", out_count, 3'd4);
        advance();

        // Random traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            drive(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 199) != 0);
            advance();
        end
        for (int c = 0; c < 4; c++) begin
            drive(8'h00, 0, 0, 0, 1, 1);
            advance();
        end

        // 10-bit pixels, three lanes
        e2 = 30'(10'h3FF) | (30'(10'h001) << 10) | (30'(10'h155) << 20);
        v2 = 1'b1; p2 = 10'h3FF;
        @(negedge clk); chk("w10_ready0", rdy2, 1'b1);
        @(posedge clk); #1; p2 = 10'h001;
        @(negedge clk); chk("w10_ready1", rdy2, 1'b1);
        @(posedge clk); #1; p2 = 10'h155;
        @(negedge clk); chk("w10_ready2", rdy2, 1'b1);
        @(posedge clk); #1; v2 = 1'b0;
        @(negedge clk);
        chk("w10_out_valid", ov2, 1'b1);
        chk("w10_out_word", ow2, e2);
        chk("w10_out_count", oc2, 2'd3);
        chk("w10_out_last", ol2, 1'b0);
        if (ov2) $display("word %08h count %0d last %0d", ow2, oc2, ol2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
